// File: rtl/udma_rx_lin_arb.sv
// udma_rx_lin_arb: round-robin merge of RX linear channels into one registered beat stream.
// Optional per-channel beat counters are enabled by defining UDMA_RX_ARB_STATS_EN.
module udma_rx_lin_arb #(
  parameter int N_CH   = 11,
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_CH-1:0]        ch_valid_i,
  input  logic [N_CH*DATA_W-1:0] ch_data_i,
  input  logic [N_CH*2-1:0]      ch_size_i,
  input  logic [N_CH-1:0]        ch_en_i,
  output logic [N_CH-1:0]        ch_ready_o,
`ifdef UDMA_RX_ARB_STATS_EN
  input  logic [ID_W-1:0]        stat_sel_i,
  input  logic                   stat_clr_i,
  output logic [15:0]            stat_cnt_o,
`endif
  output logic                   out_valid_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [1:0]             out_size_o,
  output logic [ID_W-1:0]        out_id_o,
  input  logic                   out_ready_i
);
  logic [N_CH-1:0]   w_req;
  logic [ID_W-1:0]   r_ptr, w_gnt;
  logic              w_found, w_load, w_hs;
  logic [1:0]        w_sz;
  logic [DATA_W-1:0] w_data, w_mask;

  assign w_req  = ch_valid_i & ch_en_i;
  assign w_load = !out_valid_o || out_ready_i;
  assign w_hs   = w_load && w_found;

  // Scan offsets from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    for (int i = N_CH; i >= 1; i--) begin
      if (w_req[ID_W'((int'(r_ptr) + i) % N_CH)]) begin
        w_found = 1'b1;
        w_gnt   = ID_W'((int'(r_ptr) + i) % N_CH);
      end
    end
  end

  assign w_sz       = ch_size_i[int'(w_gnt)*2 +: 2];
  assign w_data     = ch_data_i[int'(w_gnt)*DATA_W +: DATA_W];
  assign w_mask     = (w_sz == 2'b00) ? DATA_W'(8'hFF) : (w_sz == 2'b01) ? DATA_W'(16'hFFFF) : '1;
  assign ch_ready_o = w_hs ? (N_CH'(1) << w_gnt) : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_size_o  <= '0;
      out_id_o    <= '0;
      r_ptr       <= ID_W'(N_CH - 1);
    end else if (w_hs) begin
      out_valid_o <= 1'b1;
      out_data_o  <= w_data & w_mask;
      out_size_o  <= (w_sz == 2'b11) ? 2'b10 : w_sz;
      out_id_o    <= w_gnt;
      r_ptr       <= w_gnt;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef UDMA_RX_ARB_STATS_EN
  logic [15:0] r_cnt [N_CH];

  // A clear on the selected counter overrides a same-cycle increment.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_CH; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (stat_clr_i && stat_sel_i == ID_W'(k)) r_cnt[k] <= '0;
        else if (w_hs && w_gnt == ID_W'(k) && r_cnt[k] != 16'hFFFF) r_cnt[k] <= r_cnt[k] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_cnt_o = '0;
    for (int k = 0; k < N_CH; k++) if (stat_sel_i == ID_W'(k)) stat_cnt_o = r_cnt[k];
  end
`endif
endmodule

// File: tb/tb_udma_rx_lin_arb.sv
// tb_udma_rx_lin_arb: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_udma_rx_lin_arb;
  localparam int N_CH = 11;
  localparam int DW   = 32;
  localparam int IW   = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    s;
    logic [IW-1:0] id;
  } beat_t;

  logic              clk, rstn_i;
  logic [N_CH-1:0]   ch_valid, ch_en, ch_ready;
  logic [N_CH*DW-1:0] ch_data;
  logic [N_CH*2-1:0] ch_size;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_size;
  logic [IW-1:0]     out_id;
`ifdef UDMA_RX_ARB_STATS_EN
  logic [IW-1:0]     stat_sel;
  logic              stat_clr;
  logic [15:0]       stat_cnt;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q[$];

  udma_rx_lin_arb #(.N_CH(N_CH), .DATA_W(DW), .ID_W(IW)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .ch_valid_i(ch_valid), .ch_data_i(ch_data), .ch_size_i(ch_size), .ch_en_i(ch_en),
    .ch_ready_o(ch_ready),
`ifdef UDMA_RX_ARB_STATS_EN
    .stat_sel_i(stat_sel), .stat_clr_i(stat_clr), .stat_cnt_o(stat_cnt),
`endif
    .out_valid_o(out_valid), .out_data_o(out_data), .out_size_o(out_size), .out_id_o(out_id),
    .out_ready_i(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] d, input logic [1:0] s);
    ch_data[k*DW +: DW] = d;
    ch_size[k*2 +: 2]   = s;
    ch_valid[k]         = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [1:0] s, input int id);
    exp_q.push_back('{d: d, s: s, id: IW'(id)});
  endtask

  task automatic do_reset();
    ch_valid = '0;
    ch_data  = '0;
    ch_size  = '0;
    ch_en    = '1;
    out_ready = 1'b0;
`ifdef UDMA_RX_ARB_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    rstn_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;
  endtask

  // Monitor: every output handshake is checked against the head of the expectation queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rstn_i && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got id %0d data %0h, none expected", out_id, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(out_data), 64'(e.d));
          chk("beat_size", 64'(out_size), 64'(e.s));
          chk("beat_id", 64'(out_id), 64'(e.id));
        end
      end
    end
  end

  initial begin
    int order [6] = '{0, 4, 10, 0, 4, 10};
    do_reset();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_size", 64'(out_size), 0);
    chk("rst_id", 64'(out_id), 0);

    out_ready = 1'b1;
    set_ch(3, 32'hAABBCCDD, 2'b01);
    push(32'h0000CCDD, 2'b01, 3);
    @(negedge clk);
    chk("t1_ready", 64'(ch_ready), 64'(1 << 3));
    tick();
    ch_valid = '0;
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 1);
    tick();
    @(negedge clk);
    chk("t1_drained", 64'(out_valid), 0);

    do_reset();
    out_ready = 1'b1;
    set_ch(0, 32'h11111111, 2'b10);
    set_ch(4, 32'h44444444, 2'b10);
    set_ch(10, 32'hAAAA5555, 2'b10);
    for (int i = 0; i < 6; i++) push(ch_data[order[i]*DW +: DW], 2'b10, order[i]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_ready", 64'(ch_ready), 64'(1 << order[i]));
      if (i > 0) chk("rr_valid", 64'(out_valid), 1);
      tick();
    end
    ch_valid = '0;
    tick();

    do_reset();
    set_ch(2, 32'h12345678, 2'b00);
    push(32'h00000078, 2'b00, 2);
    push(32'h0000DEF0, 2'b01, 2);
    @(negedge clk);
    chk("bp_first_ready", 64'(ch_ready), 64'(1 << 2));
    tick();
    set_ch(2, 32'h9ABCDEF0, 2'b01);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 64'(ch_ready), 0);
      chk("bp_valid", 64'(out_valid), 1);
      chk("bp_data", 64'(out_data), 64'h78);
      chk("bp_id", 64'(out_id), 2);
      chk("bp_size", 64'(out_size), 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_reload_ready", 64'(ch_ready), 64'(1 << 2));
    tick();
    ch_valid = '0;
    tick();
    tick();

    do_reset();
    out_ready = 1'b1;
    ch_en[5] = 1'b0;
    set_ch(5, 32'h55555555, 2'b10);
    set_ch(6, 32'hF0F01234, 2'b11);
    repeat (3) push(32'hF0F01234, 2'b10, 6);
    repeat (3) begin
      @(negedge clk);
      chk("en_ready", 64'(ch_ready), 64'(1 << 6));
      tick();
    end
    ch_en[6] = 1'b0;
    @(negedge clk);
    chk("en_fall_ready", 64'(ch_ready), 0);
    tick();
    ch_valid = '0;
    ch_en = '1;
    tick();

    do_reset();
    set_ch(1, 32'hDEADBEEF, 2'b10);
    tick();
    chk("mid_loaded", 64'(out_valid), 1);
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_data", 64'(out_data), 0);
    ch_valid = '0;
    @(posedge clk);
    #1 rstn_i = 1'b1;
    out_ready = 1'b1;
    set_ch(9, 32'h99999999, 2'b10);
    set_ch(7, 32'h77777777, 2'b01);
    push(32'h00007777, 2'b01, 7);
    @(negedge clk);
    chk("post_rst_ready", 64'(ch_ready), 64'(1 << 7));
    tick();
    ch_valid = '0;
    tick();
    tick();

`ifdef UDMA_RX_ARB_STATS_EN
    do_reset();
    out_ready = 1'b1;
    stat_sel = 4'd1;
    set_ch(1, 32'h123456A5, 2'b00);
    repeat (32'h10002) push(32'h000000A5, 2'b00, 1);
    repeat (32'h10002) tick();
    chk("stat_sat", 64'(stat_cnt), 64'hFFFF);
    push(32'h000000A5, 2'b00, 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    ch_valid = '0;
    chk("stat_clr", 64'(stat_cnt), 0);
    stat_sel = 4'd15;
    #1;
    chk("stat_oob", 64'(stat_cnt), 0);
    tick();
`endif

    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
